// File: rtl/simon_game_ctrl_if.sv
// Sequence-memory port between the Simon sequencer (master) and its colour RAM (slave).
// Read data is registered in the memory: valid one clock after the address.
interface simon_game_ctrl_if #(
  parameter int MAX_LEN = 16
);
  localparam int AW = $clog2(MAX_LEN);

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [1:0]    mem_wdata;
  logic [1:0]    mem_rdata;

  modport master (output mem_addr, mem_we, mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, mem_we, mem_wdata, output mem_rdata);
endinterface

// File: rtl/simon_game_ctrl.sv
// Simon Says sequencer: grows a random colour sequence, plays it on the LEDs,
// then walks the player's presses through the external compare block.
module simon_game_ctrl #(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 50_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     on_off,
  input  logic                     start,
  input  logic                     btn_valid,
  input  logic [3:0]               sw,
  input  logic [1:0]               rand_in,
  input  logic                     correct_input,
  simon_game_ctrl_if.master        mem,
  output logic [1:0]               cmp_actual,
  output logic [3:0]               led,
  output logic [$clog2(MAX_LEN):0] level,
  output logic                     busy,
  output logic                     win,
  output logic                     lose
);
  localparam int AW   = $clog2(MAX_LEN);
  localparam int LW   = AW + 1;
  localparam int CMX1 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CMAX = (CMX1 > TIMEOUT_CYCLES) ? CMX1 : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, EXTEND, PFETCH, SHOW_ON, SHOW_OFF, IFETCH, WAIT_IN, WIN, LOSE
  } state_t;

  state_t          st;
  logic [AW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   idx_nxt;

  // The player's colour goes straight to the compare block; only its verdict is used here.
  logic unused_sw;
  assign unused_sw = ^sw;

  assign idx_nxt = {1'b0, idx} + LW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      level         <= '0;
      win           <= 1'b0;
      lose          <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_wdata <= '0;
    end else if (!on_off) begin
      st            <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      level         <= '0;
      win           <= 1'b0;
      lose          <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_wdata <= '0;
    end else begin
      mem.mem_we <= 1'b0;
      case (st)
        IDLE, WIN, LOSE: begin
          if (start) begin
            st            <= EXTEND;
            level         <= '0;
            win           <= 1'b0;
            lose          <= 1'b0;
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= rand_in;
          end
        end
        EXTEND: begin
          level        <= level + LW'(1);
          idx          <= '0;
          mem.mem_addr <= '0;
          st           <= PFETCH;
        end
        PFETCH: begin
          cnt <= '0;
          st  <= SHOW_ON;
        end
        SHOW_ON: begin
          if (cnt == SHOW_LAST) begin
            cnt <= '0;
            st  <= SHOW_OFF;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHOW_OFF: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (idx_nxt == level) begin
              idx          <= '0;
              mem.mem_addr <= '0;
              st           <= IFETCH;
            end else begin
              idx          <= idx_nxt[AW-1:0];
              mem.mem_addr <= idx_nxt[AW-1:0];
              st           <= PFETCH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IFETCH: begin
          cnt <= '0;
          st  <= WAIT_IN;
        end
        WAIT_IN: begin
          // A press on the very cycle the timeout expires still counts as a press.
          if (btn_valid) begin
            if (!correct_input) begin
              lose <= 1'b1;
              st   <= LOSE;
            end else if (idx_nxt < level) begin
              idx          <= idx_nxt[AW-1:0];
              mem.mem_addr <= idx_nxt[AW-1:0];
              st           <= IFETCH;
            end else if (level == LW'(MAX_LEN)) begin
              win <= 1'b1;
              st  <= WIN;
            end else begin
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= level[AW-1:0];
              mem.mem_wdata <= rand_in;
              st            <= EXTEND;
            end
          end else if (cnt == TMO_LAST) begin
            lose <= 1'b1;
            st   <= LOSE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Read data is stable while the address is held, so the display decodes it directly.
  always_comb begin
    led        = 4'b0000;
    cmp_actual = 2'b00;
    busy       = 1'b0;
    case (st)
      EXTEND, PFETCH, SHOW_OFF: busy = 1'b1;
      SHOW_ON: begin
        busy = 1'b1;
        led  = 4'b0001 << mem.mem_rdata;
      end
      WAIT_IN: cmp_actual = mem.mem_rdata;
      WIN:     led = 4'b1111;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed game scenarios with randomized colours and press delays, checked against
// a sequence-level model of the game (colour queue plus per-round expectations).
module tb_simon_game_ctrl;
  localparam int MAXL = 4;
  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int TMO  = 8;

  logic       clk = 1'b0;
  logic       reset, on_off, start, btn_valid, correct_input;
  logic [3:0] sw;
  logic [1:0] rand_in, cmp_actual;
  logic [3:0] led;
  logic [2:0] level;
  logic       busy, win, lose;

  int errors = 0;
  int checks = 0;
  int seq[$];
  int rand_cap;

  simon_game_ctrl_if #(.MAX_LEN(MAXL)) mem ();
  logic [1:0] marr [MAXL];

  simon_game_ctrl #(
    .MAX_LEN(MAXL), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .on_off(on_off), .start(start), .btn_valid(btn_valid),
    .sw(sw), .rand_in(rand_in), .correct_input(correct_input), .mem(mem),
    .cmp_actual(cmp_actual), .led(led), .level(level), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  // Sequence RAM with one-clock registered read.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAXL; i++) marr[i] <= 2'd0;
    end else if (mem.mem_we) begin
      marr[mem.mem_addr] <= mem.mem_wdata;
    end
    mem.mem_rdata <= marr[mem.mem_addr];
  end

  // Compare block: the one-hot press must match the expected colour.
  assign correct_input = (sw == (4'b0001 << cmp_actual));

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int r);
    rand_in  = 2'(r);
    rand_cap = r;
    seq.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic expect_extend();
    chk("ext_we", mem.mem_we, 1);
    chk("ext_addr", mem.mem_addr, seq.size());
    chk("ext_wdata", mem.mem_wdata, rand_cap);
    chk("ext_busy", busy, 1);
    chk("ext_level", level, seq.size());
    seq.push_back(rand_cap);
    rand_in = 2'($urandom_range(0, 3));
  endtask

  task automatic playback();
    for (int i = 0; i < seq.size(); i++) begin
      step();
      chk("pf_led", led, 0);
      chk("pf_busy", busy, 1);
      chk("pf_we", mem.mem_we, 0);
      chk("pf_level", level, seq.size());
      for (int s = 0; s < SHOW; s++) begin
        step();
        chk("show_led", led, 1 << seq[i]);
      end
      for (int g = 0; g < GAP; g++) begin
        step();
        chk("gap_led", led, 0);
        chk("gap_busy", busy, 1);
      end
    end
    step();
    chk("ifetch_busy", busy, 0);
    chk("ifetch_led", led, 0);
    step();
  endtask

  task automatic press(input int k, input bit good, input int nr);
    int d;
    d = $urandom_range(0, 5);
    repeat (d) begin
      chk("wait_cmp", cmp_actual, seq[k]);
      chk("wait_busy", busy, 0);
      step();
    end
    chk("press_cmp", cmp_actual, seq[k]);
    if (good) sw = 4'(1 << seq[k]);
    else      sw = 4'(1 << ((seq[k] + int'($urandom_range(1, 3))) % 4));
    rand_in  = (nr < 0) ? 2'($urandom_range(0, 3)) : 2'(nr);
    rand_cap = int'(rand_in);
    btn_valid = 1'b1;
    step();
    btn_valid = 1'b0;
    sw = 4'b0000;
    if (!good) begin
      chk("lose_flag", lose, 1);
      chk("lose_win", win, 0);
      chk("lose_led", led, 0);
      chk("lose_busy", busy, 0);
    end else if (k + 1 < seq.size()) begin
      chk("next_busy", busy, 0);
      chk("next_lose", lose, 0);
      step();
    end else if (seq.size() == MAXL) begin
      chk("win_flag", win, 1);
      chk("win_led", led, 4'b1111);
    end
  endtask

  task automatic run_level(input int fail_at, input int nr);
    expect_extend();
    playback();
    for (int k = 0; k < seq.size(); k++) begin
      press(k, k != fail_at, nr);
      if (k == fail_at) break;
    end
  endtask

  initial begin
    reset = 1'b0; on_off = 1'b1; start = 1'b0; btn_valid = 1'b0;
    sw = 4'b0000; rand_in = 2'd0;
    step(); step();
    chk("rst_led", led, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {win, lose}, 0);
    chk("rst_mem", {mem.mem_we, mem.mem_addr}, 0);
    chk("rst_cmp", cmp_actual, 0);
    reset = 1'b1;
    step();

    btn_valid = 1'b1;
    step();
    btn_valid = 1'b0;
    chk("idle_btn_busy", busy, 0);
    chk("idle_btn_level", level, 0);
    chk("idle_btn_flags", {win, lose}, 0);

    // Build {1,3,0}, extend to four colours, then finish the game.
    do_start(1);
    run_level(-1, 3);
    run_level(-1, 0);
    run_level(-1, -1);
    run_level(-1, -1);

    btn_valid = 1'b1;
    step();
    btn_valid = 1'b0;
    chk("win_hold", win, 1);
    chk("win_hold_led", led, 4'b1111);
    chk("win_hold_level", level, MAXL);

    // start and a press together in WIN: start must win.
    btn_valid = 1'b1;
    do_start(2);
    btn_valid = 1'b0;
    chk("restart_win_clr", win, 0);
    run_level(-1, -1);
    run_level(1, -1);

    btn_valid = 1'b1;
    step();
    btn_valid = 1'b0;
    chk("lose_hold", lose, 1);
    chk("lose_hold_busy", busy, 0);

    // Timeout with no press.
    do_start(int'($urandom_range(0, 3)));
    chk("restart_lose_clr", lose, 0);
    expect_extend();
    playback();
    for (int i = 1; i <= TMO; i++) begin
      step();
      chk("tmo_lose", lose, (i == TMO) ? 1 : 0);
    end

    // Power dropped while waiting for a press.
    do_start(int'($urandom_range(0, 3)));
    expect_extend();
    playback();
    chk("pre_off_cmp", cmp_actual, seq[0]);
    on_off = 1'b0;
    start  = 1'b1;
    step();
    chk("off_level", level, 0);
    chk("off_busy", busy, 0);
    chk("off_cmp", cmp_actual, 0);
    chk("off_flags", {win, lose}, 0);
    step();
    chk("off_start_busy", busy, 0);
    start  = 1'b0;
    on_off = 1'b1;
    step();
    chk("on_idle_busy", busy, 0);

    // Asynchronous reset in the middle of a level-3 colour.
    do_start(int'($urandom_range(0, 3)));
    run_level(-1, -1);
    run_level(-1, -1);
    expect_extend();
    step();
    step();
    chk("mid_show_led", led, 1 << seq[0]);
    chk("mid_show_level", level, 3);
    #2 reset = 1'b0;
    #1;
    chk("async_led", led, 0);
    chk("async_level", level, 0);
    chk("async_busy", busy, 0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_level", level, 0);

    do_start(3);
    expect_extend();
    playback();
    press(0, 1'b1, -1);
    chk("final_ext_we", mem.mem_we, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
